instr_exec_unit: RTL and testbench

INSTR_EXEC_UNIT -- requirements
Module: instr_exec_unit

---
 rtl/instr_exec_unit.sv | 189 ++++++++++++++++++
 tb/tb_instr_exec_unit.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec_unit.sv
// Sequential executor: fetches one instruction per step from an external register file and evaluates a signed ALU op.
// Three cycles per instruction (FETCH/EXEC/OUT); OUT holds the result until res_ready, so the consumer can stall indefinitely.
module instr_exec_unit #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] start_ptr,
  input  logic [5:0]    count,
  output logic [AW-1:0] read_pointer,
  input  logic [67:0]   instruction_word,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [63:0]   result,
  output logic [3:0]    res_opcode,
  output logic [AW-1:0] res_ptr,
  output logic          res_err,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [5:0] MAX_COUNT = 6'd32;

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_PASSA = 4'd1;
  localparam logic [3:0] OP_PASSB = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MULT  = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_MOD   = 4'd7;

  state_t             r_state;
  state_t             w_next_state;

  logic [AW-1:0]      r_ptr;
  logic [5:0]         r_remaining;
  logic [67:0]        r_instr;
  logic               r_res_valid;
  logic [63:0]        r_result;
  logic [3:0]         r_res_opcode;
  logic [AW-1:0]      r_res_ptr;
  logic               r_res_err;
  logic               r_done;

  logic               w_busy;
  logic               w_load;
  logic               w_hs;

  logic [3:0]         w_op;
  logic signed [63:0] w_a;
  logic signed [63:0] w_b;
  logic signed [63:0] w_div_b;
  logic signed [63:0] w_quot;
  logic signed [63:0] w_rem;
  logic signed [63:0] w_prod;
  logic               w_b_zero;
  logic [63:0]        w_result;
  logic               w_err;

  // Operands are widened to 64 bits so that MULT and -2^31/-1 cannot overflow.
  assign w_op     = r_instr[67:64];
  assign w_a      = {{32{r_instr[63]}}, r_instr[63:32]};
  assign w_b      = {{32{r_instr[31]}}, r_instr[31:0]};
  assign w_b_zero = (r_instr[31:0] == 32'd0);
  assign w_div_b  = w_b_zero ? 64'sd1 : w_b;
  assign w_quot   = w_a / w_div_b;
  assign w_rem    = w_a % w_div_b;
  assign w_prod   = w_a * w_b;

  always_comb begin
    w_result = 64'd0;
    w_err    = 1'b0;
    case (w_op)
      OP_ZERO:  w_result = 64'd0;
      OP_PASSA: w_result = w_a;
      OP_PASSB: w_result = w_b;
      OP_ADD:   w_result = w_a + w_b;
      OP_SUB:   w_result = w_a - w_b;
      OP_MULT:  w_result = w_prod;
      OP_DIV: begin
        w_result = w_b_zero ? 64'd0 : w_quot;
        w_err    = w_b_zero;
      end
      OP_MOD: begin
        w_result = w_b_zero ? 64'd0 : w_rem;
        w_err    = w_b_zero;
      end
      default: begin
        w_result = 64'd0;
        w_err    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = (count == 6'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_OUT;
      S_OUT: begin
        if (w_hs) begin
          w_next_state = (r_remaining == 6'd1) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
    w_load = (r_state == S_IDLE) && start && (count != 6'd0);
    w_hs   = (r_state == S_OUT) && r_res_valid && res_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr        <= '0;
      r_remaining  <= 6'd0;
      r_instr      <= 68'd0;
      r_res_valid  <= 1'b0;
      r_result     <= 64'd0;
      r_res_opcode <= 4'd0;
      r_res_ptr    <= '0;
      r_res_err    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // done is registered so it is high exactly while the FSM sits in DONE.
      r_done <= (w_next_state == S_DONE);

      if (w_load) begin
        r_ptr       <= start_ptr;
        r_remaining <= (count > MAX_COUNT) ? MAX_COUNT : count;
      end

      if (r_state == S_FETCH) begin
        r_instr <= instruction_word;
      end

      if (r_state == S_EXEC) begin
        r_result     <= w_result;
        r_res_err    <= w_err;
        r_res_opcode <= w_op;
        r_res_ptr    <= r_ptr;
        r_res_valid  <= 1'b1;
      end

      if (w_hs) begin
        r_res_valid <= 1'b0;
        r_ptr       <= r_ptr + {{(AW-1){1'b0}}, 1'b1};
        r_remaining <= r_remaining - 6'd1;
      end
    end
  end

  assign read_pointer = r_ptr;
  assign res_valid    = r_res_valid;
  assign result       = r_result;
  assign res_opcode   = r_res_opcode;
  assign res_ptr      = r_res_ptr;
  assign res_err      = r_res_err;
  assign busy         = w_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: directed scenarios plus randomized programs checked against an arithmetic reference model.
module tb_instr_exec_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [4:0]  start_ptr;
  logic [5:0]  count;
  logic [4:0]  read_pointer;
  logic [67:0] instruction_word;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] result;
  logic [3:0]  res_opcode;
  logic [4:0]  res_ptr;
  logic        res_err;
  logic        busy;
  logic        done;

  logic [67:0] mem [0:31];
  assign instruction_word = mem[read_pointer];

  int n_cmp;
  int n_fail;

  logic [63:0] q_res [$];
  logic [4:0]  q_ptr [$];
  logic [3:0]  q_op  [$];
  logic        q_err [$];

  instr_exec_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_ptr        (start_ptr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .result           (result),
    .res_opcode       (res_opcode),
    .res_ptr          (res_ptr),
    .res_err          (res_err),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [67:0] mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    return {op, a, b};
  endfunction

  // Reference: signed magnitudes divided, then the sign is restored by the arithmetic rules.
  function automatic void model(input logic [67:0] w, output logic [63:0] r, output logic e);
    int     a32, b32;
    longint a, b, ma, mb, q, rm;
    a32 = w[63:32];
    b32 = w[31:0];
    a = a32;
    b = b32;
    r = 64'd0;
    e = 1'b0;
    case (w[67:64])
      4'd0: r = 64'd0;
      4'd1: r = a;
      4'd2: r = b;
      4'd3: r = a + b;
      4'd4: r = a - b;
      4'd5: r = a * b;
      4'd6, 4'd7: begin
        if (b == 0) begin
          e = 1'b1;
        end else begin
          ma = (a < 0) ? -a : a;
          mb = (b < 0) ? -b : b;
          q  = ma / mb;
          rm = ma - q * mb;
          if (w[67:64] == 4'd6) r = ((a < 0) != (b < 0)) ? -q : q;
          else                  r = (a < 0) ? -rm : rm;
        end
      end
      default: e = 1'b1;
    endcase
  endfunction

  function automatic logic [67:0] rand_instr();
    logic [3:0]  op;
    logic [31:0] a, b;
    op = 4'($urandom_range(15));
    a  = $urandom;
    b  = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
    if ($urandom_range(7) == 0) begin
      a = 32'h8000_0000;
      b = 32'hFFFF_FFFF;
    end
    return {op, a, b};
  endfunction

  // Starts a run and records every handshake; returns after the cycle following done.
  task automatic collect(input logic [4:0] sp, input logic [5:0] cnt, input int ready_pct,
                         output bit got_done);
    q_res.delete();
    q_ptr.delete();
    q_op.delete();
    q_err.delete();
    got_done  = 1'b0;
    start_ptr = sp;
    count     = cnt;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      res_ready = ($urandom_range(99) < ready_pct);
      if (res_valid && res_ready) begin
        q_res.push_back(result);
        q_ptr.push_back(res_ptr);
        q_op.push_back(res_opcode);
        q_err.push_back(res_err);
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      tick();
    end
    res_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    start     = 1'b0;
    start_ptr = 5'd0;
    count     = 6'd0;
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if ({res_valid, result, res_opcode, res_ptr, res_err, busy, done, read_pointer} !== 80'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b result=%0h op=%0h ptr=%0d err=%0b busy=%0b done=%0b rp=%0d expected all zero",
               res_valid, result, res_opcode, res_ptr, res_err, busy, done, read_pointer);
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%0b done=%0b expected 0 0", busy, done);
    end
  endtask

  task automatic test_single();
    mem[3]    = mk(4'd3, 5, -7);
    start_ptr = 5'd3;
    count     = 6'd1;
    res_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || res_valid !== 1'b0 || read_pointer !== 5'd3) begin
      n_fail++;
      $display("FAIL single_fetch: got busy=%0b valid=%0b rp=%0d expected 1 0 3", busy, res_valid, read_pointer);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_exec_valid: got %0b expected 0", res_valid);
    end
    tick();
    n_cmp++;
    if (res_valid !== 1'b1 || result !== 64'hFFFF_FFFF_FFFF_FFFE || res_ptr !== 5'd3 ||
        res_err !== 1'b0 || res_opcode !== 4'd3) begin
      n_fail++;
      $display("FAIL single_result: got valid=%0b result=%0h ptr=%0d err=%0b op=%0d expected 1 fffffffffffffffe 3 0 3",
               res_valid, result, res_ptr, res_err, res_opcode);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got done=%0b valid=%0b expected 1 0", done, res_valid);
    end
    res_ready = 1'b0;
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got done=%0b busy=%0b expected 0 0", done, busy);
    end
  endtask

  task automatic test_arith();
    logic [63:0] exp_r [0:6];
    bit          gd;
    mem[10] = mk(4'd5, 32'h8000_0000, 32'h8000_0000);
    mem[11] = mk(4'd6, -7, 2);
    mem[12] = mk(4'd7, -7, 2);
    mem[13] = mk(4'd6, 32'h8000_0000, -1);
    mem[14] = mk(4'd7, 32'h8000_0000, -1);
    mem[15] = mk(4'd4, 32'h8000_0000, 1);
    mem[16] = mk(4'd2, 0, -1);
    exp_r[0] = 64'h4000_0000_0000_0000;
    exp_r[1] = 64'hFFFF_FFFF_FFFF_FFFD;
    exp_r[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_r[3] = 64'h0000_0000_8000_0000;
    exp_r[4] = 64'h0000_0000_0000_0000;
    exp_r[5] = 64'hFFFF_FFFF_7FFF_FFFF;
    exp_r[6] = 64'hFFFF_FFFF_FFFF_FFFF;
    collect(5'd10, 6'd7, 100, gd);
    n_cmp++;
    if (!gd || q_res.size() != 7) begin
      n_fail++;
      $display("FAIL arith_count: got done=%0b results=%0d expected 1 7", gd, q_res.size());
    end
    for (int i = 0; i < q_res.size() && i < 7; i++) begin
      n_cmp++;
      if (q_res[i] !== exp_r[i] || q_err[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL arith_%0d: got result=%0h err=%0b expected %0h 0", i, q_res[i], q_err[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_errors();
    bit gd;
    mem[20] = mk(4'd6, 9, 0);
    mem[21] = mk(4'd12, 11, 22);
    mem[22] = mk(4'd7, -5, 0);
    mem[23] = mk(4'd3, 1, 2);
    collect(5'd20, 6'd4, 100, gd);
    n_cmp++;
    if (!gd || q_res.size() != 4) begin
      n_fail++;
      $display("FAIL err_count: got done=%0b results=%0d expected 1 4", gd, q_res.size());
    end
    for (int i = 0; i < q_res.size() && i < 4; i++) begin
      n_cmp++;
      if (q_res[i] !== ((i == 3) ? 64'd3 : 64'd0) || q_err[i] !== (i != 3) ||
          q_op[i] !== mem[20 + i][67:64]) begin
        n_fail++;
        $display("FAIL err_%0d: got result=%0h err=%0b op=%0d expected %0d %0b %0d",
                 i, q_res[i], q_err[i], q_op[i], (i == 3) ? 3 : 0, i != 3, mem[20 + i][67:64]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [4:0]  exp_p [0:3];
    logic [63:0] er;
    logic        ee;
    bit          gd;
    exp_p[0] = 5'd30; exp_p[1] = 5'd31; exp_p[2] = 5'd0; exp_p[3] = 5'd1;
    for (int i = 0; i < 4; i++) mem[exp_p[i]] = rand_instr();
    collect(5'd30, 6'd4, 70, gd);
    n_cmp++;
    if (!gd || q_res.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_count: got done=%0b results=%0d expected 1 4", gd, q_res.size());
    end
    for (int i = 0; i < q_res.size() && i < 4; i++) begin
      model(mem[exp_p[i]], er, ee);
      n_cmp++;
      if (q_ptr[i] !== exp_p[i] || q_res[i] !== er || q_err[i] !== ee) begin
        n_fail++;
        $display("FAIL wrap_%0d: got ptr=%0d result=%0h err=%0b expected %0d %0h %0b",
                 i, q_ptr[i], q_res[i], q_err[i], exp_p[i], er, ee);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] er;
    logic        ee;
    int          hs;
    bit          seen;
    logic [4:0]  last_ptr;
    mem[5] = mk(4'd5, 1234, -3);
    mem[6] = mk(4'd4, 100, 250);
    model(mem[5], er, ee);
    res_ready = 1'b0;
    start_ptr = 5'd5;
    count     = 6'd2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (res_valid) seen = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bp_first_valid: got no res_valid within 10 cycles expected one");
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        start     = 1'b1;
        start_ptr = 5'd20;
        count     = 6'd7;
      end
      tick();
      start = 1'b0;
      n_cmp++;
      if (res_valid !== 1'b1 || result !== er || res_err !== ee || res_ptr !== 5'd5 ||
          res_opcode !== 4'd5 || read_pointer !== 5'd5) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got valid=%0b result=%0h err=%0b ptr=%0d op=%0d rp=%0d expected 1 %0h %0b 5 5 5",
                 k, res_valid, result, res_err, res_ptr, res_opcode, read_pointer, er, ee);
      end
    end
    hs       = 0;
    seen     = 1'b0;
    last_ptr = 5'd0;
    res_ready = 1'b1;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (res_valid) begin
        hs++;
        last_ptr = res_ptr;
      end
      if (done) seen = 1'b1;
      tick();
    end
    res_ready = 1'b0;
    tick();
    n_cmp++;
    if (!seen || hs != 2 || last_ptr !== 5'd6 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_complete: got done=%0b handshakes=%0d last_ptr=%0d busy=%0b expected 1 2 6 0",
               seen, hs, last_ptr, busy);
    end
    start     = 1'b1;
    count     = 6'd0;
    start_ptr = 5'd9;
    tick();
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count_done: got done=%0b valid=%0b expected 1 0", done, res_valid);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count_idle: got done=%0b busy=%0b valid=%0b expected 0 0 0", done, busy, res_valid);
    end
  endtask

  task automatic test_clamp();
    bit gd;
    bit ptr_ok;
    for (int i = 0; i < 32; i++) mem[i] = rand_instr();
    collect(5'd0, 6'd40, 100, gd);
    ptr_ok = 1'b1;
    for (int i = 0; i < q_ptr.size(); i++) if (q_ptr[i] !== 5'(i)) ptr_ok = 1'b0;
    n_cmp++;
    if (!gd || q_res.size() != 32 || !ptr_ok) begin
      n_fail++;
      $display("FAIL clamp_count: got done=%0b results=%0d ptr_seq_ok=%0b expected 1 32 1", gd, q_res.size(), ptr_ok);
    end
  endtask

  task automatic test_reset_mid_run();
    int          hs;
    bit          at_second;
    bit          quiet;
    bit          gd;
    logic [63:0] er;
    logic        ee;
    for (int i = 0; i < 32; i++) mem[i] = rand_instr();
    res_ready = 1'b1;
    start_ptr = 5'd10;
    count     = 6'd4;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    hs        = 0;
    at_second = 1'b0;
    for (int c = 0; c < 30 && !at_second; c++) begin
      if (res_valid && hs == 1) begin
        at_second = 1'b1;
      end else begin
        if (res_valid && res_ready) hs++;
        tick();
      end
    end
    n_cmp++;
    if (!at_second || res_ptr !== 5'd11) begin
      n_fail++;
      $display("FAIL rst_reach_second: got reached=%0b ptr=%0d expected 1 11", at_second, res_ptr);
    end
    res_ready = 1'b0;
    reset_n   = 1'b0;
    tick();
    n_cmp++;
    if ({res_valid, result, res_opcode, res_ptr, res_err, busy, done, read_pointer} !== 80'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got valid=%0b result=%0h op=%0h ptr=%0d err=%0b busy=%0b done=%0b rp=%0d expected all zero",
               res_valid, result, res_opcode, res_ptr, res_err, busy, done, read_pointer);
    end
    tick();
    reset_n   = 1'b1;
    res_ready = 1'b1;
    quiet     = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (res_valid || done || busy) quiet = 1'b0;
    end
    n_cmp++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL rst_quiet: got activity after reset expected none");
    end
    collect(5'd20, 6'd2, 80, gd);
    n_cmp++;
    if (!gd || q_res.size() != 2) begin
      n_fail++;
      $display("FAIL rst_restart_count: got done=%0b results=%0d expected 1 2", gd, q_res.size());
    end
    for (int i = 0; i < q_res.size() && i < 2; i++) begin
      model(mem[20 + i], er, ee);
      n_cmp++;
      if (q_ptr[i] !== 5'(20 + i) || q_res[i] !== er || q_err[i] !== ee) begin
        n_fail++;
        $display("FAIL rst_restart_%0d: got ptr=%0d result=%0h err=%0b expected %0d %0h %0b",
                 i, q_ptr[i], q_res[i], q_err[i], 20 + i, er, ee);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]  sp;
    logic [5:0]  cnt;
    logic [4:0]  p;
    logic [63:0] er;
    logic        ee;
    bit          gd;
    for (int run = 0; run < 8; run++) begin
      for (int i = 0; i < 32; i++) mem[i] = rand_instr();
      sp  = 5'($urandom_range(31));
      cnt = 6'($urandom_range(10, 1));
      collect(sp, cnt, 60, gd);
      n_cmp++;
      if (!gd || q_res.size() != int'(cnt)) begin
        n_fail++;
        $display("FAIL rand_%0d_count: got done=%0b results=%0d expected 1 %0d", run, gd, q_res.size(), cnt);
      end
      for (int i = 0; i < q_res.size() && i < int'(cnt); i++) begin
        p = 5'((int'(sp) + i) % 32);
        model(mem[p], er, ee);
        n_cmp++;
        if (q_ptr[i] !== p || q_op[i] !== mem[p][67:64] || q_res[i] !== er || q_err[i] !== ee) begin
          n_fail++;
          $display("FAIL rand_%0d_%0d: got ptr=%0d op=%0d result=%0h err=%0b expected %0d %0d %0h %0b",
                   run, i, q_ptr[i], q_op[i], q_res[i], q_err[i], p, mem[p][67:64], er, ee);
        end
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) mem[i] = 68'd0;
    test_reset();
    test_single();
    test_arith();
    test_errors();
    test_wrap();
    test_backpressure();
    test_clamp();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
